main_control: RTL and testbench
===============================

Name: main_control

Overview:
- Channel-selection controller for a 4-input MPEG2-TS QoS switch.
- Chooses which of four transport-stream channels drives the output mux, based on per-channel signal presence (valid), per-channel error counters, a programmable priority order and a manual override.
- Configured and monitored by the host CPU through a simple memory-mapped register interface.
- Sits between the channel monitors (valid/err_count producers) and the 4:1 output mux.

Parameters:
- None. Channel count is fixed at 4, error counters are 8 bits each and the timer is 20 bits.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- valid  in  4  signal presence; ch1=[0], ch2=[1], ch3=[2], ch4=[3].
- err_count  in  32  error counts, unsigned; ch1=[7:0], ch2=[15:8], ch3=[23:16], ch4=[31:24].
- mm_write_en  in  1  register write strobe, one cycle.
- mm_read_en  in  1  register read strobe, one cycle.
- mm_addr  in  8  register address.
- mm_wdata  in  32  write data.
- mm_rdata  out  32  read data, registered.
- mux_control  out  2  selected channel index; 0=ch1 … 3=ch4.
- en_mux  out  1  high when the selected channel is valid.
- timer  out  20  current evaluation-timer count.

Behaviour:
- Reset (rst high at a rising clk edge):
  - mux_control=0, en_mux=0, timer=0, mm_rdata=0.
  - Config register=0.
- Register map:
  - 0x00 CFG, R/W: [0] fallback_enable, [1] manual_enable, [3:2] manual_channel, [11:4] channel_priority, [31:12] reset_timer.
  - 0x01 STATUS, RO: [1:0] mux_control, [5:2] valid, [31:6]=0.
  - 0x02 ERRORS, RO: live err_count[31:0].
  - Any other address reads 0.
- Writes:
  - When mm_write_en=1 at a clk edge with mm_addr=0x00, CFG loads mm_wdata on that edge.
  - Writes to other addresses are ignored.
- Reads:
  - When mm_read_en=1 at a clk edge, mm_rdata is loaded with the addressed value on that edge.
  - Read data holds until the next read. Latency is one cycle.
  - Simultaneous read and write of 0x00 returns the pre-write value.
- Priority order: channel_priority holds four 2-bit channel indices.
  - [7:6] is rank 0 (highest), then [5:4], [3:2], [1:0] (lowest).
  - Duplicate indices are allowed; a channel not listed is never chosen automatically.
- Timer:
  - If reset_timer=0, timer is held at 0.
  - Otherwise timer increments each cycle from 0 to reset_timer-1, then wraps to 0.
  - The wrap cycle (timer==reset_timer-1) is the evaluation tick.
  - Writing CFG clears timer to 0 on the next edge.
- Automatic selection (manual_enable=0):
  - On each evaluation tick, select the valid channel with the lowest err_count.
  - Ties go to the better rank in channel_priority.
  - If no listed channel is valid, mux_control holds its value.
- Manual selection (manual_enable=1): mux_control = manual_channel, updated on the cycle after the CFG write.
- Fallback:
  - Applies when fallback_enable=1 and the currently selected channel (manual or automatic) has valid=0.
  - mux_control switches on the next edge, not waiting for a tick, to the highest-ranked valid channel.
  - In manual mode the override resumes automatically once manual_channel becomes valid again.
  - With fallback_enable=0, the selection stays on the invalid channel.
- en_mux: registered; en_mux = valid[mux_control] as evaluated on the same edge mux_control updates.
- mux_control changes only on clk edges; there is no glitching.

Test Plan:
- Reset, then read 0x00, 0x01 and 0x02 with valid=0 and err_count=0 → all read 0; mux_control=0, en_mux=0, timer=0.
- Write CFG=(reset_timer=30, priority=8'b11_01_00_10, manual=0, fallback=1), valid=4'hF → timer counts 0..29 and wraps. At each tick mux_control = index of the minimum err_count, ties resolved toward ch4, then ch2, ch1, ch3. Reading 0x00 returns the written word.
- Same config, then write manual_enable=1, manual_channel=3 → mux_control=3 on the cycle after the write; en_mux=1; STATUS reads 0x3F.
- Manual channel 3 selected, fallback=1, drop valid[3] → next edge mux_control=1 (next rank: ch2), en_mux=1. Restoring valid[3] returns mux_control to 3.
- Same as the previous case but with fallback=0 → mux_control stays 3 and en_mux=0.
- Drive err_count=32'h0A14281E and read 0x02 → mm_rdata=32'h0A14281E one cycle after the read strobe. Reads of address 0x05 return 0.

Source files
------------

// File: rtl/main_control.sv
// main_control: channel-selection controller for a 4-input MPEG2-TS QoS switch.
// Picks which of four transport-stream channels drives the output mux from
// per-channel presence, error counts, a programmable rank order and a manual
// override. Host access is through a small memory-mapped register file.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   valid[3:0]   per-channel signal presence (bit n = channel n+1)
//   err_count    four 8-bit unsigned error counts (byte n = channel n+1)
//   mm_write_en  register write strobe
//   mm_read_en   register read strobe
//   mm_addr      register address (0x00 CFG, 0x01 STATUS, 0x02 ERRORS)
//   mm_wdata     write data
//   mm_rdata     registered read data, holds until the next read
//   mux_control  selected channel index (0 = ch1 .. 3 = ch4)
//   en_mux       selected channel is valid
//   timer        evaluation-timer count
module main_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  valid,
    input  logic [31:0] err_count,
    input  logic        mm_write_en,
    input  logic        mm_read_en,
    input  logic [7:0]  mm_addr,
    input  logic [31:0] mm_wdata,
    output logic [31:0] mm_rdata,
    output logic [1:0]  mux_control,
    output logic        en_mux,
    output logic [19:0] timer
);

    logic [31:0] cfg;
    logic        fallback_enable;
    logic        manual_enable;
    logic [1:0]  manual_channel;
    logic [7:0]  channel_priority;
    logic [19:0] reset_timer;

    assign fallback_enable  = cfg[0];
    assign manual_enable    = cfg[1];
    assign manual_channel   = cfg[3:2];
    assign channel_priority = cfg[11:4];
    assign reset_timer      = cfg[31:12];

    logic cfg_write;
    logic tick;

    assign cfg_write = mm_write_en && (mm_addr == 8'h00);
    assign tick      = (reset_timer != '0) && (timer == reset_timer - 20'd1);

    // Rank 0 (highest) lives in the top bits of channel_priority.
    logic [1:0] rank_ch [4];
    logic [7:0] err_ch  [4];

    assign rank_ch[0] = channel_priority[7:6];
    assign rank_ch[1] = channel_priority[5:4];
    assign rank_ch[2] = channel_priority[3:2];
    assign rank_ch[3] = channel_priority[1:0];

    assign err_ch[0] = err_count[7:0];
    assign err_ch[1] = err_count[15:8];
    assign err_ch[2] = err_count[23:16];
    assign err_ch[3] = err_count[31:24];

    // Walk the ranks once: the first valid entry is the fallback target, and
    // a strictly-lower error count is needed to displace an earlier rank, so
    // ties resolve toward the better rank.
    logic       fb_found;
    logic [1:0] fb_ch;
    logic       best_found;
    logic [1:0] best_ch;
    logic [7:0] best_err;
    logic [1:0] ch;

    always_comb begin
        fb_found   = 1'b0;
        fb_ch      = mux_control;
        best_found = 1'b0;
        best_ch    = mux_control;
        best_err   = '1;
        ch         = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            ch = rank_ch[r[1:0]];
            if (valid[ch]) begin
                if (!fb_found) begin
                    fb_found = 1'b1;
                    fb_ch    = ch;
                end
                if (!best_found || (err_ch[ch] < best_err)) begin
                    best_found = 1'b1;
                    best_ch    = ch;
                    best_err   = err_ch[ch];
                end
            end
        end
    end

    logic [1:0] next_mux;

    always_comb begin
        next_mux = mux_control;
        if (manual_enable) begin
            // Override is re-asserted every cycle, so it resumes by itself
            // once the manual channel comes back.
            if (!fallback_enable || valid[manual_channel])
                next_mux = manual_channel;
            else if (fb_found)
                next_mux = fb_ch;
        end else begin
            if (tick && best_found)
                next_mux = best_ch;
            else if (fallback_enable && !valid[mux_control] && fb_found)
                next_mux = fb_ch;
        end
    end

    logic [31:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (mm_addr)
            8'h00:   rd_val = cfg;
            8'h01:   rd_val = {26'd0, valid, mux_control};
            8'h02:   rd_val = err_count;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg         <= '0;
            timer       <= '0;
            mux_control <= '0;
            en_mux      <= 1'b0;
            mm_rdata    <= '0;
        end else begin
            if (cfg_write)
                cfg <= mm_wdata;

            if (cfg_write || (reset_timer == '0) || tick)
                timer <= '0;
            else
                timer <= timer + 20'd1;

            mux_control <= next_mux;
            en_mux      <= valid[next_mux];

            if (mm_read_en)
                mm_rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_main_control.sv
// tb_main_control: self-checking bench for main_control. Directed steps follow
// the feature list, then a randomized phase; every cycle all outputs are
// compared with a behavioural model that works on whole configuration words.
module tb_main_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] err_count;
    logic        mm_write_en;
    logic        mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic [1:0]  mux_control;
    logic        en_mux;
    logic [19:0] timer;

    always #5 clk = ~clk;

    main_control dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .err_count   (err_count),
        .mm_write_en (mm_write_en),
        .mm_read_en  (mm_read_en),
        .mm_addr     (mm_addr),
        .mm_wdata    (mm_wdata),
        .mm_rdata    (mm_rdata),
        .mux_control (mux_control),
        .en_mux      (en_mux),
        .timer       (timer)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_cfg;
    int          m_timer;
    int          m_mux;
    int          m_en;
    logic [31:0] m_rdata;

    // Channel listed at a given rank (rank 0 is the highest).
    function automatic int prio_ch(input logic [31:0] cfg, input int rank);
        int p;
        p = int'(cfg[11:4]);
        return (p >> (6 - 2 * rank)) % 4;
    endfunction

    function automatic int err_of(input logic [31:0] e, input int c);
        return int'((e >> (8 * c)) & 32'hFF);
    endfunction

    // Highest-ranked listed channel that is valid, or -1.
    function automatic int first_valid(input logic [31:0] cfg, input logic [3:0] v);
        for (int r = 0; r < 4; r++)
            if (v[prio_ch(cfg, r)]) return prio_ch(cfg, r);
        return -1;
    endfunction

    // Lowest error count among valid listed channels; ties -> earliest rank.
    function automatic int min_err_ch(input logic [31:0] cfg, input logic [3:0] v,
                                      input logic [31:0] e);
        int lo;
        lo = 1000;
        for (int r = 0; r < 4; r++)
            if (v[prio_ch(cfg, r)] && err_of(e, prio_ch(cfg, r)) < lo)
                lo = err_of(e, prio_ch(cfg, r));
        if (lo == 1000) return -1;
        for (int r = 0; r < 4; r++)
            if (v[prio_ch(cfg, r)] && err_of(e, prio_ch(cfg, r)) == lo)
                return prio_ch(cfg, r);
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs now on the pins, clock
    // the DUT, then compare every output 1 ns after the edge.
    task automatic step();
        int rt, sel, nmux, ntimer;
        logic tick;
        logic [31:0] ncfg, nrd;
        if (rst) begin
            ncfg = '0; ntimer = 0; nmux = 0; nrd = '0;
        end else begin
            rt   = int'(m_cfg[31:12]);
            tick = (rt != 0) && (m_timer == rt - 1);
            nmux = m_mux;
            if (m_cfg[1]) begin
                sel = int'(m_cfg[3:2]);
                if (!m_cfg[0] || valid[sel]) nmux = sel;
                else if (first_valid(m_cfg, valid) >= 0) nmux = first_valid(m_cfg, valid);
            end else if (tick && min_err_ch(m_cfg, valid, err_count) >= 0) begin
                nmux = min_err_ch(m_cfg, valid, err_count);
            end else if (m_cfg[0] && !valid[m_mux] && first_valid(m_cfg, valid) >= 0) begin
                nmux = first_valid(m_cfg, valid);
            end
            ncfg = (mm_write_en && mm_addr == 8'h00) ? mm_wdata : m_cfg;
            if ((mm_write_en && mm_addr == 8'h00) || rt == 0 || tick) ntimer = 0;
            else ntimer = m_timer + 1;
            nrd = m_rdata;
            if (mm_read_en) begin
                if (mm_addr == 8'h00)      nrd = m_cfg;
                else if (mm_addr == 8'h01) nrd = 32'(valid) * 4 + 32'(m_mux);
                else if (mm_addr == 8'h02) nrd = err_count;
                else                       nrd = '0;
            end
        end
        m_en = rst ? 0 : int'(valid[nmux]);
        @(posedge clk);
        m_cfg = ncfg; m_timer = ntimer; m_mux = nmux; m_rdata = nrd;
        #1;
        chk("mux_control", 32'(mux_control), 32'(m_mux));
        chk("en_mux",      32'(en_mux),      32'(m_en));
        chk("timer",       32'(timer),       32'(m_timer));
        chk("mm_rdata",    mm_rdata,         m_rdata);
    endtask

    task automatic idle();
        mm_write_en = 1'b0; mm_read_en = 1'b0; mm_addr = 8'h00; mm_wdata = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        mm_write_en = 1'b1; mm_read_en = 1'b0; mm_addr = a; mm_wdata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [7:0] a);
        mm_write_en = 1'b0; mm_read_en = 1'b1; mm_addr = a;
        step();
        idle();
    endtask

    initial begin
        m_cfg = '0; m_timer = 0; m_mux = 0; m_en = 0; m_rdata = '0;
        rst = 1'b1; valid = '0; err_count = '0;
        idle();
        @(negedge clk);

        // Reset and empty reads.
        step(); step();
        rst = 1'b0;
        chk("rst_mux", 32'(mux_control), 32'd0);
        chk("rst_timer", 32'(timer), 32'd0);
        rd(8'h00); chk("rd_cfg0", mm_rdata, 32'd0);
        rd(8'h01); chk("rd_status0", mm_rdata, 32'd0);
        rd(8'h02); chk("rd_err0", mm_rdata, 32'd0);

        // Automatic selection, reset_timer=30, ranks ch4,ch2,ch1,ch3, fallback on.
        valid = 4'hF;
        wr(8'h00, 32'h0001_ED21);
        rd(8'h00); chk("rd_cfg", mm_rdata, 32'h0001_ED21);
        err_count = 32'h0505_0505;
        for (int i = 0; i < 35; i++) step();
        chk("tie_all_ch4", 32'(mux_control), 32'd3);
        for (int i = 0; i < 100; i++) begin
            err_count = {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)};
            step();
        end

        // Manual override to ch4.
        wr(8'h00, 32'h0001_ED2F);
        step();
        chk("manual_ch4", 32'(mux_control), 32'd3);
        chk("manual_en", 32'(en_mux), 32'd1);
        rd(8'h01); chk("status_3f", mm_rdata, 32'h0000_003F);

        // Fallback from manual ch4 to ch2, then back.
        valid = 4'b0111; step();
        chk("fallback_ch2", 32'(mux_control), 32'd1);
        chk("fallback_en", 32'(en_mux), 32'd1);
        valid = 4'hF; step();
        chk("manual_resume", 32'(mux_control), 32'd3);

        // Fallback disabled: stays on the dead channel.
        wr(8'h00, 32'h0001_ED2E);
        step();
        valid = 4'b0111; step();
        chk("nofb_stay", 32'(mux_control), 32'd3);
        chk("nofb_en", 32'(en_mux), 32'd0);
        valid = 4'hF;

        // ERRORS register and unmapped address.
        err_count = 32'h0A14_281E;
        rd(8'h02); chk("rd_errors", mm_rdata, 32'h0A14_281E);
        rd(8'h05); chk("rd_unmapped", mm_rdata, 32'd0);
        step(); chk("rd_hold", mm_rdata, 32'd0);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 4) == 0) valid = 4'($urandom);
            if ($urandom_range(0, 2) == 0)
                err_count = {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)};
            else if ($urandom_range(0, 5) == 0)
                err_count = $urandom;
            case ($urandom_range(0, 19))
                0, 1: begin
                    mm_write_en = 1'b1;
                    mm_addr     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                    mm_wdata    = {20'($urandom_range(0, 9)), 12'($urandom)};
                end
                2, 3, 4: begin
                    mm_read_en = 1'b1;
                    mm_addr    = 8'($urandom_range(0, 5));
                end
                5: begin
                    mm_write_en = 1'b1; mm_read_en = 1'b1; mm_addr = 8'h00;
                    mm_wdata    = {20'($urandom_range(0, 9)), 12'($urandom)};
                end
                default: ;
            endcase
            step();
        end
        rst = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
